// File: rtl/conv1d_pkg.sv
// Shared widths for the conv1d streaming convolution engine.
package conv1d_pkg;
  localparam int WIDTH_DATA = 16;
  localparam int ACC_WIDTH  = 2 * WIDTH_DATA;
endpackage

// File: rtl/conv1d_tap.sv
// One transposed-form FIR stage: weight register, multiplier, adder, acc register
// and (for stages after the first) the d register that delays the upstream acc.
// CONV1D_SAT_EN selects a saturating adder in place of wrap-around.
module conv1d_tap
  import conv1d_pkg::*;
#(
  parameter int WIDTH = WIDTH_DATA,
  parameter bit HAS_D = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_valid_i,
  input  logic signed [WIDTH-1:0]   w_i,
  input  logic signed [WIDTH-1:0]   x_r_i,
  input  logic signed [2*WIDTH-1:0] chain_i,
  output logic signed [2*WIDTH-1:0] acc_o
);
  localparam int AW = 2 * WIDTH;

  logic signed [WIDTH-1:0] w_q;
  logic signed [AW-1:0]    acc_q, acc_d, addend, prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      if (w_valid_i) w_q <= w_i;
      acc_q <= acc_d;
    end
  end

  generate
    if (HAS_D) begin : g_d
      logic signed [AW-1:0] d_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= '0;
        else        d_q <= chain_i;
      end
      assign addend = d_q;
    end else begin : g_no_d
      assign addend = chain_i;
    end
  endgenerate

  assign prod = AW'(w_q) * AW'(x_r_i);

`ifdef CONV1D_SAT_EN
  // One guard bit exposes overflow; clamp when the top two bits disagree.
  logic signed [AW:0] sum_g;
  assign sum_g = {addend[AW-1], addend} + {prod[AW-1], prod};
  always_comb begin
    acc_d = sum_g[AW-1:0];
    if (sum_g[AW] != sum_g[AW-1])
      acc_d = sum_g[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end
`else
  assign acc_d = addend + prod;
`endif

  assign acc_o = acc_q;
endmodule

// File: rtl/conv1d.sv
// Streaming systolic 1-D convolution: x is registered once and broadcast to k taps,
// bias enters at tap 0 and the result leaves from the last tap's acc register.
module conv1d
  import conv1d_pkg::*;
#(
  parameter int k     = 3,
  parameter int WIDTH = WIDTH_DATA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_valid,
  input  logic [k*WIDTH-1:0]        w_in,
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] y
);
  localparam int AW = 2 * WIDTH;

  logic signed [WIDTH-1:0] x_r_q;
  logic signed [AW-1:0]    acc_w [k];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_r_q <= '0;
    else        x_r_q <= x;
  end

  generate
    for (genvar gi = 0; gi < k; gi++) begin : g_tap
      logic signed [AW-1:0] chain;
      if (gi == 0) begin : g_head
        assign chain = AW'(b);
      end else begin : g_body
        assign chain = acc_w[gi-1];
      end

      conv1d_tap #(
        .WIDTH (WIDTH),
        .HAS_D (gi != 0)
      ) u_tap (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_valid_i (w_valid),
        .w_i       ($signed(w_in[gi*WIDTH +: WIDTH])),
        .x_r_i     (x_r_q),
        .chain_i   (chain),
        .acc_o     (acc_w[gi])
      );
    end
  endgenerate

  assign y = acc_w[k-1];
endmodule

// File: tb/tb_conv1d.sv
// Directed bench for conv1d (k=3 and k=1 instances) with a cycle-level chain model.
module tb_conv1d;
  localparam int W = 16;
  localparam int K = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                w_valid;
  logic [K*W-1:0]      w_in;
  logic signed [W-1:0] x, b;
  logic signed [2*W-1:0] y;

  logic                w1_valid;
  logic [W-1:0]        w1_in;
  logic signed [W-1:0] x1, b1;
  logic signed [2*W-1:0] y1;

  int n_checks = 0;
  int n_errors = 0;

  conv1d #(.k(K), .WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_in(w_in), .x(x), .b(b), .y(y)
  );
  conv1d #(.k(1), .WIDTH(W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .w_valid(w1_valid), .w_in(w1_in), .x(x1), .b(b1), .y(y1)
  );

  always #5 clk = ~clk;

  // Reference state for the k=3 instance.
  logic signed [W-1:0]   mw [K];
  logic signed [W-1:0]   mx;
  logic signed [2*W-1:0] macc [K];
  logic signed [2*W-1:0] md [K-1];

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end else begin
      $display("ok   %s: %0d", tag, $signed(got));
    end
  endtask

  function automatic logic signed [2*W-1:0] madd(input logic signed [2*W-1:0] a,
                                                 input logic signed [2*W-1:0] p);
`ifdef CONV1D_SAT_EN
    logic signed [2*W:0] s;
    s = {a[2*W-1], a} + {p[2*W-1], p};
    if (s > 33'sd2147483647)  return 32'sh7fffffff;
    if (s < -33'sd2147483648) return 32'sh80000000;
    return s[2*W-1:0];
`else
    return a + p;
`endif
  endfunction

  task automatic model_clear();
    mx = '0;
    for (int i = 0; i < K; i++) begin mw[i] = '0; macc[i] = '0; end
    for (int i = 0; i < K-1; i++) md[i] = '0;
  endtask

  task automatic model_edge();
    logic signed [2*W-1:0] nacc [K];
    nacc[0] = madd(32'(b), 32'(mw[0]) * 32'(mx));
    for (int i = 1; i < K; i++) nacc[i] = madd(md[i-1], 32'(mw[i]) * 32'(mx));
    for (int i = 1; i < K; i++) md[i-1] = macc[i-1];
    for (int i = 0; i < K; i++) macc[i] = nacc[i];
    mx = x;
    if (w_valid) for (int i = 0; i < K; i++) mw[i] = $signed(w_in[i*W +: W]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, y, macc[K-1]);
  endtask

  function automatic logic [K*W-1:0] pack3(input int w0, input int w1, input int w2);
    logic [W-1:0] a, bb, c;
    a = W'(w0); bb = W'(w1); c = W'(w2);
    return {c, bb, a};
  endfunction

  initial begin
    int imp_exp [6];
    imp_exp = '{9, 5, 2, 5, 7, 5};
    rst_n = 1'b0; w_valid = 1'b0; w_in = '0; x = '0; b = '0;
    w1_valid = 1'b0; w1_in = '0; x1 = '0; b1 = '0;
    model_clear();
    #2;
    check("reset_y", y, 32'd0);
    check("reset_y_k1", y1, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Impulse: w=[2,-3,4] held two cycles, b=5.
    w_in = pack3(2, -3, 4); w_valid = 1'b1; b = 5;
    tick("load0"); tick("load1");
    w_valid = 1'b0;
    repeat (8) tick("settle");
    check("imp_steady", y, 32'd5);
    x = 1;
    tick("imp_t0");
    x = 0;
    for (int i = 0; i < 6; i++) begin
      tick("imp_model");
      check($sformatf("imp_e%0d", i + 1), y, 32'(imp_exp[i]));
    end

    // Random stream with random weights and bias.
    w_in = pack3($random % 10, $random % 10, $random % 10); w_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      x = W'($random); b = W'($random % 10);
      tick("rand");
      w_valid = 1'b0;
    end

    // Mid-stream reload, then w_in changes that must be ignored.
    w_in = pack3(1, 1, 1); w_valid = 1'b1;
    x = W'($random); tick("reload");
    w_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w_in = pack3($random % 10, $random % 10, $random % 10);
      x = W'($random); b = W'($random % 10);
      tick("reload_hold");
    end

    // Overflow: every product is 2^30.
    w_in = pack3(-32768, -32768, -32768); w_valid = 1'b1;
    x = -16'sd32768; b = 16'sd32767;
    tick("ovf_load");
    w_valid = 1'b0;
    repeat (8) tick("ovf");
`ifdef CONV1D_SAT_EN
    check("ovf_value", y, 32'h7fffffff);
`else
    check("ovf_value", y, 32'hc0007fff);
`endif

    // Asynchronous reset mid-stream with live weights and x.
    x = 16'sd123; b = 3;
    tick("pre_rst");
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst", y, 32'd0);
    check("async_rst_k1", y1, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    w_valid = 1'b0; w_in = pack3(7, 7, 7); b = 5;
    for (int i = 0; i < 6; i++) begin
      x = W'($random);
      tick("post_rst");
    end
    check("rst_settle", y, 32'd5);

    // k=1 instance: w=3, b=1, x steps 0 -> 2.
    w1_in = 16'd3; w1_valid = 1'b1; b1 = 1; x1 = 0;
    @(posedge clk); #1 w1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("k1_pre", y1, 32'd1);
    x1 = 2;
    @(posedge clk); #1 check("k1_t0", y1, 32'd1);
    @(posedge clk); #1 check("k1_step", y1, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
